data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the memory stage of the RV32I core and a handshaked backing RAM. Serves byte/half/word loads and stores with the core's `type_control` / `sign_ext_flag` encoding. Read hits complete in zero added cycles. Misses and all stores raise `stall` until the backing RAM has serviced them.

---
 rtl/data_cache_pkg.sv | 28 ++
 rtl/data_cache_if.sv | 26 ++
 rtl/data_cache_load_extend.sv | 26 ++
 rtl/data_cache.sv | 177 +++++++++++++++++
 tb/tb_data_cache.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and width helpers for the data cache slice.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2,
    ST_WRITE  = 2'd3
  } cache_state_e;

  // Access sizes as encoded on the core's type_control; 2'b11 behaves as word.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Backing-RAM bus between the cache (master) and the RAM (slave).
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata/mem_wstrb
// and holds all of them stable until the slave answers with a one-cycle
// mem_ack (mem_rdata valid in that same cycle); an ack while mem_req=0 means nothing.
interface data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/data_cache_load_extend.sv
// Load lane select and sign/zero extension, shared with the uncached path.
module load_extend
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            byte_off,
  input  logic [1:0]            type_control,
  input  logic                  sign_ext_flag,
  output logic [DATA_WIDTH-1:0] result
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane, then extend it to the full data width.
  always_comb begin
    lane_b = word[{byte_off, 3'b000} +: 8];
    lane_h = byte_off[1] ? word[31:16] : word[15:0];
    case (type_control)
      SZ_BYTE: result = {{(DATA_WIDTH-8){sign_ext_flag & lane_b[7]}}, lane_b};
      SZ_HALF: result = {{(DATA_WIDTH-16){sign_ext_flag & lane_h[15]}}, lane_h};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
module data_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [1:0]            type_control,
  input  logic                  sign_ext_flag,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  data_cache_if.master          mem,
  output cache_state_e          state_dbg
);
  localparam int OFF_W = off_width(LINE_WORDS);
  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, SETS, LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  cache_state_e state_q, state_d;
  logic [OFF_W-1:0] beat_q;

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

  // Request-side address fields (core holds them stable while stalled).
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF_W-1:0] req_woff;
  // Line being refilled or written, taken from the registered bus address.
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] line_tag;
  logic [OFF_W-1:0] line_woff;

  logic hit, ack_ok, start_refill, start_write;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_wstrb;

  assign req_idx   = addr[2+OFF_W +: IDX_W];
  assign req_tag   = addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_woff  = addr[2 +: OFF_W];
  assign line_idx  = mem.mem_addr[2+OFF_W +: IDX_W];
  assign line_tag  = mem.mem_addr[ADDR_WIDTH-1 -: TAG_W];
  assign line_woff = mem.mem_addr[2 +: OFF_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign ack_ok    = mem.mem_ack && mem.mem_req;
  assign state_dbg = state_q;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .word          (data_q[req_idx][req_woff]),
    .byte_off      (addr[1:0]),
    .type_control  (type_control),
    .sign_ext_flag (sign_ext_flag),
    .result        (read_data)
  );

  // Store lane replication and byte enables for the RAM write.
  always_comb begin
    st_wdata = write_data;
    st_wstrb = 4'b1111;
    case (type_control)
      SZ_HALF: begin
        st_wdata = {(DATA_WIDTH/16){write_data[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: begin
        st_wdata = {(DATA_WIDTH/8){write_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and stall decode.
  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    start_refill = 1'b0;
    start_write  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_write) begin
          stall       = 1'b1;
          start_write = 1'b1;
          state_d     = ST_WRITE;
        end else if (req_valid && !hit) begin
          stall        = 1'b1;
          start_refill = 1'b1;
          state_d      = ST_REFILL;
        end
      end
      ST_REFILL: begin
        stall = 1'b1;
        if (ack_ok && beat_q == LAST_BEAT) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_WRITE: begin
        // The ack cycle is the retire cycle, so the core is released in it.
        stall = !ack_ok;
        if (ack_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered RAM request fields and refill beat counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
      beat_q        <= '0;
    end else if (start_refill) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
      mem.mem_wstrb <= '0;
      beat_q        <= '0;
    end else if (start_write) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= 1'b1;
      mem.mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
      mem.mem_wdata <= st_wdata;
      mem.mem_wstrb <= st_wstrb;
    end else if (state_q == ST_REFILL && ack_ok) begin
      if (beat_q == LAST_BEAT) begin
        mem.mem_req <= 1'b0;
        beat_q      <= '0;
      end else begin
        beat_q                   <= beat_q + OFF_W'(1);
        mem.mem_addr[2 +: OFF_W] <= beat_q + OFF_W'(1);
      end
    end else if (state_q == ST_WRITE && ack_ok) begin
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 1'b0;
    end
  end

  // Valid bits: set when the last refill beat lands, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else if (state_q == ST_REFILL && ack_ok && beat_q == LAST_BEAT)
      valid_q[line_idx] <= 1'b1;
  end

  // Tag and data arrays: refill beats and write-through merge on store hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_REFILL && ack_ok) begin
        data_q[line_idx][beat_q] <= mem.mem_rdata;
        if (beat_q == LAST_BEAT) tag_q[line_idx] <= line_tag;
      end
      if (state_q == ST_WRITE && ack_ok && valid_q[line_idx] && tag_q[line_idx] == line_tag) begin
        for (int b = 0; b < 4; b++) begin
          if (mem.mem_wstrb[b]) data_q[line_idx][line_woff][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a latency-configurable backing RAM model.
module tb_data_cache;
  import cache_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [1:0]  type_control = 2'b00;
  logic        sign_ext_flag = 1'b0;
  logic [31:0] read_data;
  logic        stall;
  cache_state_e state_dbg;

  data_cache_if bus ();

  data_cache dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .addr          (addr),
    .write_data    (write_data),
    .type_control  (type_control),
    .sign_ext_flag (sign_ext_flag),
    .read_data     (read_data),
    .stall         (stall),
    .mem           (bus),
    .state_dbg     (state_dbg)
  );

  // Backing RAM model: initial contents come from init_word until a word is written.
  int          ack_lat = 1;
  int          cnt = 0;
  logic [31:0] ram [0:4095];
  bit [4095:0] wr_flag;
  logic [31:0] merged;

  logic [31:0] log_addr_q[$];
  logic [31:0] log_wdata_q[$];
  logic        log_we_q[$];
  logic [3:0]  log_strb_q[$];

  // Scoreboard queues and counters
  logic [31:0] exp_q[$];
  logic [31:0] exp_beat_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11111111;
      32'h104: return 32'h000080FF;
      32'h108: return 32'h33333333;
      32'h10C: return 32'h44444444;
      32'h500, 32'h504, 32'h508, 32'h50C: return 32'h55555555;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return wr_flag[a[13:2]] ? ram[a[13:2]] : init_word({a[31:2], 2'b00});
  endfunction

  assign bus.mem_ack   = bus.mem_req && (cnt == ack_lat - 1);
  assign bus.mem_rdata = ram_word(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack) begin
      log_addr_q.push_back(bus.mem_addr);
      log_we_q.push_back(bus.mem_we);
      log_wdata_q.push_back(bus.mem_wdata);
      log_strb_q.push_back(bus.mem_wstrb);
      if (bus.mem_we) begin
        merged = ram_word(bus.mem_addr);
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        ram[bus.mem_addr[13:2]]     <= merged;
        wr_flag[bus.mem_addr[13:2]] <= 1'b1;
      end
      cnt <= 0;
    end else if (bus.mem_req) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a load and wait (bounded) for it to complete with stall=0.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] tc,
                         input logic sx, input logic [31:0] exp, input int exp_stall);
    int n;
    n = 0;
    addr = a; type_control = tc; sign_ext_flag = sx;
    req_write = 1'b0; write_data = '0; req_valid = 1'b1;
    exp_q.push_back(exp);
    #1;
    while (stall && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " stall"}, 32'(n), 32'(exp_stall));
    check({tag, " data"}, read_data, exp_q.pop_front());
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Drive a store and wait (bounded) for its retire cycle.
  task automatic do_store(input string tag, input logic [31:0] a, input logic [1:0] tc,
                          input logic [31:0] wd);
    int n;
    n = 0;
    addr = a; type_control = tc; sign_ext_flag = 1'b0;
    req_write = 1'b1; write_data = wd; req_valid = 1'b1;
    #1;
    while (stall && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " stall"}, 32'(n), 32'(ack_lat));
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(base + 32'(4 * i));
  endtask

  // Compare logged refill beats against expected addresses, then demand no extras.
  task automatic check_beats(input string tag);
    while (exp_beat_q.size() > 0) begin
      if (log_addr_q.size() > 0) begin
        check({tag, " beat addr"}, log_addr_q.pop_front(), exp_beat_q.pop_front());
        check({tag, " beat we"}, 32'(log_we_q.pop_front()), 32'd0);
        void'(log_wdata_q.pop_front());
        void'(log_strb_q.pop_front());
      end else begin
        check({tag, " beat missing"}, 32'hFFFFFFFF, exp_beat_q.pop_front());
      end
    end
    check({tag, " extra ram ops"}, 32'(log_addr_q.size()), 32'd0);
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] strb);
    check({tag, " ram op count"}, 32'(log_addr_q.size()), 32'd1);
    if (log_addr_q.size() > 0) begin
      check({tag, " addr"}, log_addr_q.pop_front(), a);
      check({tag, " we"}, 32'(log_we_q.pop_front()), 32'd1);
      check({tag, " wdata"}, log_wdata_q.pop_front(), wd);
      check({tag, " wstrb"}, 32'(log_strb_q.pop_front()), 32'(strb));
    end
  endtask

  task automatic clear_log();
    log_addr_q.delete(); log_we_q.delete(); log_wdata_q.delete(); log_strb_q.delete();
  endtask

  initial begin
    int n;
    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // Cold word load: 5 stall cycles, four beats from 0x100
    push_line(32'h100);
    do_load("cold ld", 32'h100, SZ_WORD, 1'b0, 32'h11111111, 5);
    check_beats("cold ld");

    // Byte hits with sign and zero extension
    do_load("ldb sx", 32'h105, SZ_BYTE, 1'b1, 32'hFFFFFF80, 0);
    do_load("ldb zx", 32'h105, SZ_BYTE, 1'b0, 32'h00000080, 0);
    do_load("ldb lane0", 32'h104, SZ_BYTE, 1'b1, 32'hFFFFFFFF, 0);
    do_load("ldh lo sx", 32'h105, SZ_HALF, 1'b1, 32'hFFFF80FF, 0);
    do_load("ldh hi sx", 32'h106, SZ_HALF, 1'b1, 32'h00000000, 0);
    do_load("ldh hi zx", 32'h10A, SZ_HALF, 1'b0, 32'h00003333, 0);
    do_load("ld tc11", 32'h10F, 2'b11, 1'b1, 32'h44444444, 0);

    // Store half to a cached line, then read back the merged word
    clear_log();
    do_store("st half", 32'h102, SZ_HALF, 32'h1234BEEF);
    check_write("st half", 32'h100, 32'hBEEFBEEF, 4'b1100);
    do_load("ld merged", 32'h100, SZ_WORD, 1'b0, 32'hBEEF1111, 0);

    // Store miss: one RAM write, no allocation
    clear_log();
    do_store("st miss", 32'h2000, SZ_BYTE, 32'h000000A5);
    check_write("st miss", 32'h2000, 32'hA5A5A5A5, 4'b0001);
    push_line(32'h2000);
    do_load("ld after st miss", 32'h2000, SZ_WORD, 1'b0, 32'h000000A5, 5);
    check_beats("ld after st miss");

    // Conflict in set 16
    do_load("conf hit", 32'h100, SZ_WORD, 1'b0, 32'hBEEF1111, 0);
    push_line(32'h500);
    do_load("conf evict", 32'h500, SZ_WORD, 1'b0, 32'h55555555, 5);
    check_beats("conf evict");
    push_line(32'h100);
    do_load("conf remiss", 32'h100, SZ_WORD, 1'b0, 32'hBEEF1111, 5);
    check_beats("conf remiss");

    // Reset during a slow refill of 0x500
    ack_lat = 3;
    clear_log();
    addr = 32'h500; type_control = SZ_WORD; sign_ext_flag = 1'b0;
    req_write = 1'b0; req_valid = 1'b1;
    n = 0;
    while (log_addr_q.size() < 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("mid refill beats seen", 32'(log_addr_q.size()), 32'd2);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst mid mem_req", 32'(bus.mem_req), 32'd0);
    check("rst mid state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst mid stall", 32'(stall), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post rst mem_req", 32'(bus.mem_req), 32'd0);
    exp_beat_q.push_back(32'h500);
    exp_beat_q.push_back(32'h504);
    check_beats("partial refill");

    // Full refill from beat 0 with 3-cycle ack latency
    push_line(32'h100);
    do_load("slow refill", 32'h100, SZ_WORD, 1'b0, 32'hBEEF1111, 13);
    check_beats("slow refill");
    do_load("slow refill hit", 32'h108, SZ_WORD, 1'b0, 32'h33333333, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
